// File: rtl/sa_result_drain.sv
// -----------------------------------------------------------------------------
// sa_result_drain
//
// Downstream companion of the systolic array wrapper. Every rising edge of the
// array's `finished` level is one tile event; the signed `result_row` present
// in that cycle is summed into wide accumulators. After the programmed number
// of tiles the sums are requantized (round-half-up arithmetic shift, then
// saturation) into an output buffer and streamed one element per beat over a
// valid/ready interface.
//
// Ports:
//   clk, rstn    clock; synchronous active-low reset
//   finished     array done level (0->1 transition = one tile event)
//   result_row   MATRIX_SIZE signed DATA_WIDTH elements, element j at
//                bits [j*DATA_WIDTH +: DATA_WIDTH]
//   tiles        tiles per output vector (0 behaves as 1), latched per vector
//   shift        requantization right-shift, latched per vector
//   m_valid/m_ready/m_data/m_index/m_last   output element stream
//   busy         a finished vector waits for the output buffer
//   overflow     sticky: a tile event arrived while busy and was dropped
//   clear_ovf    clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module sa_result_drain #(
    parameter int MATRIX_SIZE = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    localparam int IDX_W      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              finished,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] result_row,
    input  logic [3:0]                        tiles,
    input  logic [3:0]                        shift,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [IDX_W-1:0]                  m_index,
    output logic                              m_last,
    output logic                              busy,
    output logic                              overflow,
    input  logic                              clear_ovf
);

    // Working width for the rounding add: must hold acc plus 2^14.
    localparam int EW = ((ACC_WIDTH > 16) ? ACC_WIDTH : 16) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PEND  = 2'd2
    } state_t;

    state_t                        state_r, state_s;
    logic                          fin_d_r;
    logic                          edge_s;
    logic                          first_s, add_s, load_s, drop_s;
    logic                          xfer_s, buf_free_s;
    logic [3:0]                    cnt_r, tiles_r, shift_r;
    logic signed [ACC_WIDTH-1:0]   acc_r [MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0]  q_s   [MATRIX_SIZE];
    logic signed [DATA_WIDTH-1:0]  buf_r [MATRIX_SIZE];
    logic                          m_valid_r, m_last_r, overflow_r;
    logic [DATA_WIDTH-1:0]         m_data_r;
    logic [IDX_W-1:0]              m_index_r, nxt_idx_s;

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] x);
        return {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    // Round-half-up arithmetic shift followed by saturation to DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] requant(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [3:0]                  sh
    );
        logic signed [EW-1:0] x, y, rnd, maxv, minv;
        logic signed [DATA_WIDTH-1:0] r;
        x    = EW'(a);
        maxv = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        minv = ~maxv;
        rnd  = {{(EW-1){1'b0}}, 1'b1} << (sh - 4'd1);
        if (sh == 4'd0) begin
            y = x;
        end else begin
            y = (x + rnd) >>> sh;
        end
        if (y > maxv) begin
            r = maxv[DATA_WIDTH-1:0];
        end else if (y < minv) begin
            r = minv[DATA_WIDTH-1:0];
        end else begin
            r = y[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    assign edge_s     = finished & ~fin_d_r;
    assign xfer_s     = m_valid_r & m_ready;
    // Free when empty, or when the last element leaves this very cycle.
    assign buf_free_s = ~m_valid_r | (xfer_s & m_last_r);
    assign nxt_idx_s  = m_index_r + IDX_W'(1);

    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign m_index  = m_index_r;
    assign m_last   = m_last_r;
    assign busy     = (state_r == PEND);
    assign overflow = overflow_r;

    // Requantized view of the accumulators using the latched shift.
    always_comb begin
        for (int j = 0; j < MATRIX_SIZE; j++) begin
            q_s[j] = requant(acc_r[j], shift_r);
        end
    end

    // Accumulator FSM: next state and datapath control strobes.
    always_comb begin
        state_s = state_r;
        first_s = 1'b0;
        add_s   = 1'b0;
        load_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (edge_s) begin
                    first_s = 1'b1;
                    state_s = (tiles <= 4'd1) ? PEND : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (edge_s) begin
                    add_s   = 1'b1;
                    state_s = (cnt_r + 4'd1 == tiles_r) ? PEND : ACCUM;
                end else begin
                    state_s = ACCUM;
                end
            end
            PEND: begin
                drop_s = edge_s;
                if (buf_free_s) begin
                    load_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = PEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Edge detector, accumulators, tile counter and per-vector settings.
    // fin_d resets high so a level already high at reset release is ignored.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fin_d_r <= 1'b1;
            cnt_r   <= 4'd0;
            tiles_r <= 4'd0;
            shift_r <= 4'd0;
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                acc_r[j] <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            fin_d_r <= finished;
            if (first_s) begin
                tiles_r <= (tiles == 4'd0) ? 4'd1 : tiles;
                shift_r <= shift;
                cnt_r   <= 4'd1;
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    acc_r[j] <= sext(result_row[j*DATA_WIDTH +: DATA_WIDTH]);
                end
            end else if (add_s) begin
                cnt_r <= cnt_r + 4'd1;
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    acc_r[j] <= acc_r[j] + sext(result_row[j*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end
    end

    // Output buffer and stream registers; a load wins over the last transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
            m_index_r <= {IDX_W{1'b0}};
            m_last_r  <= 1'b0;
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                buf_r[j] <= {DATA_WIDTH{1'b0}};
            end
        end else if (load_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= q_s[0];
            m_index_r <= {IDX_W{1'b0}};
            m_last_r  <= (MATRIX_SIZE == 1);
            for (int j = 0; j < MATRIX_SIZE; j++) begin
                buf_r[j] <= q_s[j];
            end
        end else if (xfer_s) begin
            if (m_last_r) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
                m_index_r <= {IDX_W{1'b0}};
            end else begin
                m_index_r <= nxt_idx_s;
                m_data_r  <= buf_r[nxt_idx_s];
                m_last_r  <= (nxt_idx_s == IDX_W'(MATRIX_SIZE - 1));
            end
        end
    end

    // Sticky overflow; a drop in the same cycle beats clear_ovf.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clear_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule
